chaotic_map_1: RTL and testbench
================================

// Module: chaotic_map_1
// PURPOSE
// - Fixed-point logistic-map generator: x(n+1) = r * x(n) * (1 - x(n)), all values Q8.8.
// - Produces one new chaotic sample per clock after a seed load.
// - Feeds the chaotic-LFSR datapath as a seed/perturbation source.
// - In the team's benches, out[15:7] is the displayed sample.
// PARAMETERS
// - W     16  total data width (Q8.8 at default)
// - FRAC   8  fractional bits; ONE = 1 << FRAC (256 at default)
// PORTS
// - clk     in   1  rising-edge clock; the block's only clock
// - reset   in   1  asynchronous, active-low reset (0 = in reset)
// - x_init  in   W  seed x0, Q8.8; valid range 0..ONE-1 (0.0..0.996)
// - r       in   W  control parameter, Q8.8; e.g. 998 = 3.9; range 0..1024 (0..4.0)
// - out     out  W  current state x(n), Q8.8, registered
// BEHAVIOUR
// - State: out (W bits) plus 1-bit flag `loaded`.
// - Reset (reset == 0, asynchronous)
//   - out <= 0, loaded <= 0.
//   - Held for as long as reset stays low.
// - First rising edge after reset release
//   - out <= x_init, loaded <= 1.
//   - x_init is sampled only on this edge; later changes are ignored until the next reset.
// - Every later rising edge: out <= f(out, r). r is sampled live every cycle.
// - f(x, r), all arithmetic unsigned, truncating (no rounding):
//   - p1  = (r * x) >> FRAC            2W-bit product, keep low W bits after shift
//   - om  = (x >= ONE) ? 0 : ONE - x   1 - x, clamped at 0
//   - p2  = (p1 * om) >> FRAC
//   - next = (p2 >= ONE) ? ONE - 1 : p2   saturate to 0.996; out never reaches 1.0
// - Latency: reset release -> seed on out: 1 cycle; then 1 iteration per cycle.
// - No handshake, no valid/ready; out is meaningful whenever loaded == 1.
// - Fixed points and corner cases:
//   - x = 0 stays 0.
//   - r = 0 drives out to 0 on the next cycle.
//   - x_init >= ONE gives next = 0.
// - Reset asserted mid-run: out returns to 0 immediately; the sequence restarts from a fresh x_init.
// - Pure combinational next-state (two multipliers); no pipelining.
// STRUCTURE
// - Shared package chaos_pkg:
//   - W, FRAC, ONE constants
//   - typedef q8_8_t (logic [15:0])
//   - constant Q_MAX = ONE - 1
// - One natural sub-module: logistic_step (combinational f(x, r) with clamps and saturation).
//   The top holds only the registers and the load/iterate control.
// TESTING
// - Reset low: out == 0 asynchronously, without waiting for clk.
//   After release with x_init=128, r=998: out == 128 after edge 1.
// - Continue the run above: expected sequence 249, 26, 90 on the next three edges.
// - x_init=0, r=998: out stays 0 for 10 cycles (fixed point).
// - x_init=128, r=1024: first iterate raw 256, saturates -> out == 255.
// - x_init=300 (>= ONE), r=998: first iterate out == 0.
// - Assert reset mid-run with x_init changed to 64 during the run:
//   - out drops to 0 at once.
//   - After release: 64, then (998*64>>8=249; 249*192>>8) = 186.

Source files
------------

// File: rtl/chaos_pkg.sv
// chaos_pkg: shared Q8.8 constants and sample type for the logistic-map generator
package chaos_pkg;
  localparam int W = 16;
  localparam int FRAC = 8;
  typedef logic [15:0] q8_8_t;
  localparam q8_8_t ONE = q8_8_t'(1) << FRAC;
  localparam q8_8_t Q_MAX = ONE - q8_8_t'(1);
endpackage

// File: rtl/logistic_step.sv
// logistic_step: combinational x*r*(1-x) in unsigned fixed point; ports i x, r -> o next
module logistic_step
  import chaos_pkg::*;
#(
  parameter int W = chaos_pkg::W,
  parameter int FRAC = chaos_pkg::FRAC
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] r,
  output logic [W-1:0] next
);
  localparam logic [W-1:0] L_ONE = W'(1) << FRAC;
  localparam logic [W-1:0] L_MAX = L_ONE - W'(1);
  logic [2*W-1:0] w_m1;
  logic [2*W-1:0] w_m2;
  logic [2*W-1:0] w_p2;
  logic [W-1:0] w_p1;
  logic [W-1:0] w_om;
  always_comb begin
    w_m1 = (2*W)'(r) * (2*W)'(x);
    w_p1 = W'(w_m1 >> FRAC);
    w_om = (x >= L_ONE) ? '0 : L_ONE - x;
    w_m2 = (2*W)'(w_p1) * (2*W)'(w_om);
    w_p2 = w_m2 >> FRAC;
    next = (w_p2 >= (2*W)'(L_ONE)) ? L_MAX : W'(w_p2);
  end
endmodule

// File: rtl/chaotic_map_1.sv
// chaotic_map_1: logistic-map sample generator; clk, reset (async active-low), x_init seed, r control -> out state
module chaotic_map_1
  import chaos_pkg::*;
#(
  parameter int W = chaos_pkg::W,
  parameter int FRAC = chaos_pkg::FRAC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x_init,
  input  logic [W-1:0] r,
  output logic [W-1:0] out
);
  logic [W-1:0] r_x;
  logic         r_loaded;
  logic [W-1:0] w_next;
  logistic_step #(.W(W), .FRAC(FRAC)) u_step (.x(r_x), .r(r), .next(w_next));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_x <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_loaded <= 1'b1;
      r_x <= r_loaded ? w_next : x_init;
    end
  assign out = r_x;
endmodule

// File: tb/tb_chaotic_map_1.sv
// tb_chaotic_map_1: random and directed checks of chaotic_map_1 against an arithmetic logistic-map model
module tb_chaotic_map_1;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] x_init;
  logic [15:0] r;
  logic [15:0] out;
  int errors = 0;
  int checks = 0;

  chaotic_map_1 dut (.clk(clk), .reset(reset), .x_init(x_init), .r(r), .out(out));

  always #5 clk = ~clk;

  function automatic int model(input int x, input int rr);
    longint p1, om, p2;
    p1 = ((longint'(rr) * x) / 256) % 65536;
    om = (x >= 256) ? 0 : 256 - x;
    p2 = (p1 * om) / 256;
    return (p2 >= 256) ? 255 : int'(p2);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic restart(input int xi, input int rr);
    reset = 1'b0;
    x_init = 16'(xi);
    r = 16'(rr);
    #1 chk("reset_async", int'(out), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) chk("seed", int'(out), xi);
  endtask

  initial begin
    int exp_seq[3] = '{249, 26, 90};
    int m, rr;
    reset = 1'b0;
    x_init = 16'd128;
    r = 16'd998;
    #2 chk("reset_initial", int'(out), 0);
    @(negedge clk) chk("reset_held", int'(out), 0);
    reset = 1'b1;
    @(negedge clk) chk("seed128", int'(out), 128);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) chk("seq3_9", int'(out), exp_seq[i]);
    end
    restart(0, 998);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) chk("zero_fixed", int'(out), 0);
    end
    restart(128, 1024);
    @(negedge clk) chk("saturate", int'(out), 255);
    restart(300, 998);
    @(negedge clk) chk("seed_over_one", int'(out), 0);
    restart(128, 998);
    @(negedge clk) chk("mid_iter1", int'(out), 249);
    x_init = 16'd64;
    @(negedge clk) chk("seed_ignored", int'(out), 26);
    reset = 1'b0;
    #1 chk("mid_reset_async", int'(out), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) chk("mid_reseed", int'(out), 64);
    @(negedge clk) chk("mid_iter", int'(out), 186);
    for (int run = 0; run < 20; run++) begin
      m = int'($urandom_range(0, 300));
      rr = int'($urandom_range(0, 1024));
      restart(m, rr);
      for (int i = 0; i < 15; i++) begin
        if ($urandom_range(0, 3) == 0) rr = int'($urandom_range(0, 1024));
        r = 16'(rr);
        x_init = 16'($urandom);
        @(negedge clk);
        m = model(m, rr);
        chk("random_iter", int'(out), m);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
